prim_skid_reg: RTL and testbench
================================

// Module: prim_skid_reg
// PURPOSE
//  Two-entry ready/valid register slice (skid buffer) for timing closure on streaming paths.
//  Both valid_o and ready_o are driven straight from flops, so the block cuts the forward
//  path (valid/data) and the backward path (ready) combinationally.
//  Sustains one transfer per cycle, preserves order and never drops or duplicates a beat.
//  Placed between any producer/consumer pair in the TEE datapath that uses valid/ready.
// PARAMETERS
//  Width       32   payload width in bits
//  ResetValue  '0   reset value of both data registers (Width bits); data_o shows it after reset
// PORTS
//  clk_i    in   1      clock
//  rst_ni   in   1      reset, asynchronous, active-low
//  valid_i  in   1      upstream beat valid
//  ready_o  out  1      slice can accept; registered
//  data_i   in   Width  upstream payload
//  valid_o  out  1      downstream beat valid; registered
//  ready_i  in   1      downstream accepts
//  data_o   out  Width  downstream payload = main register
// BEHAVIOUR
//  - Transfers: in_xfer = valid_i & ready_o; out_xfer = valid_o & ready_i.
//  - Reset (async): state=EMPTY, main=skid=ResetValue, valid_o=0, ready_o=0.
//    ready_o rises on the first clk_i edge after rst_ni deasserts.
//  - States (2-bit enum): EMPTY (main invalid), BUSY (main valid, skid invalid), FULL (both valid).
//  - Outputs: valid_o = (state != EMPTY); ready_o = registered (next_state != FULL).
//  - Transitions:
//    EMPTY: in_xfer -> BUSY, main<=data_i; else stay.
//    BUSY:  in&out -> BUSY, main<=data_i; in&!out -> FULL, skid<=data_i; !in&out -> EMPTY; else stay.
//    FULL:  out_xfer -> BUSY, main<=skid; else stay. ready_o=0, so valid_i is ignored.
//  - Latency: accepted beat appears on data_o/valid_o the cycle after in_xfer (1 cycle).
//  - Throughput: 1 beat/cycle while ready_i=1; FULL is reached only on downstream stall.
//  - data_o holds its last value while valid_o=0; it never shows an unwritten X.
//  - Simultaneous in_xfer and out_xfer in BUSY: old main leaves, new beat lands in main;
//    skid stays untouched.
//  - Protocol rules (assertions, not logic): once valid_i=1 and ready_o=0, valid_i and data_i
//    stay stable until accepted. The block itself keeps valid_o/data_o stable under
//    valid_o & !ready_i.
//  - Illegal state encoding 2'b11 is unreachable; the default branch returns to EMPTY and an
//    assertion fires.
//  - Reset mid-operation: all beats are discarded immediately; no partial beat is emitted
//    after release.
// STRUCTURE
//  - prim_skid_pkg: typedef enum logic [1:0] skid_state_e {SkidEmpty=2'b00, SkidBusy=2'b01,
//    SkidFull=2'b10}; localparam SkidDepth=2.
//  - Single module, no sub-module: one state register, one ready register, two Width-bit
//    data registers (main, skid) with enables. The next-state/enable logic sits in one
//    always_comb block.
//  - Assertions: valid_o/data_o stability under backpressure; ready_o==0 in FULL;
//    known outputs after reset.
// TESTING
//  1. Reset: rst_ni=0 with valid_i=1 -> valid_o=0, ready_o=0, data_o=ResetValue;
//     one cycle after release, ready_o=1.
//  2. Streaming: ready_i=1, push 0x1..0x10 back-to-back -> same 16 values on data_o,
//     1-cycle delay, no bubbles.
//  3. Stall: push 0xA, 0xB, ready_i=0 -> state FULL, ready_o=0 on cycle 3, 0xC held upstream;
//     release -> 0xA, 0xB, 0xC in order.
//  4. Simultaneous: in BUSY holding 0x5, valid_i=1 with 0x6 and ready_i=1 -> next cycle
//     data_o=0x6, skid unused, ready_o stays 1.
//  5. Random valid_i/ready_i (50% each), 10k beats against a scoreboard queue -> no loss,
//     no duplication, order kept.
//  6. Mid-stream reset while FULL (0x7, 0x8) -> valid_o=0 asynchronously;
//     after release, 0x7/0x8 never appear.

Source files
------------

// File: rtl/prim_skid_pkg.sv
// Shared types and constants for the two-entry ready/valid skid register slice.
package prim_skid_pkg;

   // Occupancy of the slice: nothing held, main held, or main and skid both held.
   typedef enum logic [1:0] {
      SkidEmpty = 2'b00,
      SkidBusy  = 2'b01,
      SkidFull  = 2'b10
   } skid_state_e;

   // Number of beats the slice can hold.
   localparam int unsigned SkidDepth = 2;

endpackage

// File: rtl/prim_skid_reg.sv
// Two-entry ready/valid register slice. valid_o and ready_o both come straight from
// flops, so the slice breaks the forward and the backward combinational paths while
// still sustaining one beat per cycle. data_o is always the main register; the skid
// register only catches the beat that was accepted while downstream stalled.
module prim_skid_reg
   import prim_skid_pkg::*;
#(
   parameter int unsigned       Width      = 32,
   parameter logic [Width-1:0]  ResetValue = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [Width-1:0] data_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [Width-1:0] data_o
);

   skid_state_e      state_q, state_d;
   logic             ready_q;
   logic [Width-1:0] main_q, skid_q;
   logic             main_en, skid_en, main_from_skid;
   logic             in_xfer, out_xfer;

   assign valid_o  = (state_q != SkidEmpty);
   assign ready_o  = ready_q;
   assign data_o   = main_q;
   assign in_xfer  = valid_i & ready_q;
   assign out_xfer = valid_o & ready_i;

   // Next occupancy and data register enables from the two handshakes.
   always_comb begin
      state_d        = state_q;
      main_en        = 1'b0;
      skid_en        = 1'b0;
      main_from_skid = 1'b0;
      case (state_q)
         SkidEmpty: begin
            if (in_xfer) begin
               state_d = SkidBusy;
               main_en = 1'b1;
            end
         end
         SkidBusy: begin
            if (in_xfer && out_xfer) begin
               main_en = 1'b1;
            end else if (in_xfer) begin
               state_d = SkidFull;
               skid_en = 1'b1;
            end else if (out_xfer) begin
               state_d = SkidEmpty;
            end
         end
         SkidFull: begin
            if (out_xfer) begin
               state_d        = SkidBusy;
               main_en        = 1'b1;
               main_from_skid = 1'b1;
            end
         end
         default: begin
            state_d = SkidEmpty;
         end
      endcase
   end

   // Occupancy and the registered ready; ready stays low through reset and rises one edge later.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= SkidEmpty;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d != SkidFull);
      end
   end

   // Payload registers; main refills from the skid entry when a stalled pair drains.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         main_q <= ResetValue;
         skid_q <= ResetValue;
      end else begin
         if (main_en) begin
            main_q <= main_from_skid ? skid_q : data_i;
         end
         if (skid_en) begin
            skid_q <= data_i;
         end
      end
   end

   // Upstream must hold a stalled beat unchanged until it is taken.
   input_stable_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (valid_i && !ready_o) |=> (valid_i && $stable(data_i)));

   // A beat offered downstream stays put until it is taken.
   output_stable_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (valid_o && !ready_i) |=> (valid_o && $stable(data_o)));

   // A full slice never advertises room.
   full_not_ready_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (state_q == SkidFull) |-> !ready_o);

   // Outputs never go unknown once out of reset.
   known_outputs_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !$isunknown({valid_o, ready_o, data_o}));

   // The unused encoding must never be entered.
   legal_state_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
      state_q != 2'b11);

endmodule

// File: tb/tb_prim_skid_reg.sv
// Self-checking bench for prim_skid_reg: table-driven cycle vectors, hand-written
// reset sequences and a random valid/ready run, all backed by a scoreboard queue.
module tb_prim_skid_reg;

   localparam int unsigned      Width      = 32;
   localparam logic [Width-1:0] ResetValue = '0;

   logic             clk_i;
   logic             rst_ni;
   logic             valid_i;
   logic             ready_o;
   logic [Width-1:0] data_i;
   logic             valid_o;
   logic             ready_i;
   logic [Width-1:0] data_o;

   typedef struct {
      logic             vi;
      logic [Width-1:0] di;
      logic             ri;
      logic             ev;
      logic             er;
      logic             cd;
      logic [Width-1:0] ed;
   } vec_t;

   vec_t             vecs [12];
   logic [Width-1:0] sb_q [$];
   int               n_tests;
   int               n_fail;

   prim_skid_reg #(
      .Width      (Width),
      .ResetValue (ResetValue)
   ) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_i  (data_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .data_o  (data_o)
   );

   // Free-running clock.
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // One comparison with a failure line on mismatch.
   task automatic checkOutput(input string name, input logic [Width-1:0] act,
                              input logic [Width-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle at the falling edge and score both handshakes before the rising edge.
   task automatic driveCycle(input logic vi, input logic [Width-1:0] di, input logic ri);
      logic [Width-1:0] exp;
      valid_i = vi;
      data_i  = di;
      ready_i = ri;
      if (valid_o && ready_i) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL sb_unexpected: got beat 0x%0h, expected no beat", data_o);
         end else begin
            exp = sb_q.pop_front();
            checkOutput("sb_data", data_o, exp);
         end
      end
      if (valid_i && ready_o) begin
         sb_q.push_back(data_i);
      end
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   // Check one table row's expected outputs, then apply its inputs.
   task automatic applyStimulus(input vec_t v);
      checkOutput("vec_valid_o", {31'd0, valid_o}, {31'd0, v.ev});
      checkOutput("vec_ready_o", {31'd0, ready_o}, {31'd0, v.er});
      if (v.cd) begin
         checkOutput("vec_data_o", data_o, v.ed);
      end
      driveCycle(v.vi, v.di, v.ri);
   endtask

   // Test sequence.
   initial begin
      logic             hold;
      logic             cur_v;
      logic [Width-1:0] cur_d;
      int               sent;
      int               cyc;
      int               guard;

      n_tests = 0;
      n_fail  = 0;

      // Stall then release, followed by a simultaneous in/out in BUSY.
      vecs[0]  = '{vi:1'b1, di:32'hA, ri:1'b0, ev:1'b0, er:1'b1, cd:1'b0, ed:32'h0};
      vecs[1]  = '{vi:1'b1, di:32'hB, ri:1'b0, ev:1'b1, er:1'b1, cd:1'b1, ed:32'hA};
      vecs[2]  = '{vi:1'b1, di:32'hC, ri:1'b0, ev:1'b1, er:1'b0, cd:1'b1, ed:32'hA};
      vecs[3]  = '{vi:1'b1, di:32'hC, ri:1'b0, ev:1'b1, er:1'b0, cd:1'b1, ed:32'hA};
      vecs[4]  = '{vi:1'b1, di:32'hC, ri:1'b1, ev:1'b1, er:1'b0, cd:1'b1, ed:32'hA};
      vecs[5]  = '{vi:1'b1, di:32'hC, ri:1'b1, ev:1'b1, er:1'b1, cd:1'b1, ed:32'hB};
      vecs[6]  = '{vi:1'b0, di:32'h0, ri:1'b1, ev:1'b1, er:1'b1, cd:1'b1, ed:32'hC};
      vecs[7]  = '{vi:1'b0, di:32'h0, ri:1'b1, ev:1'b0, er:1'b1, cd:1'b1, ed:32'hC};
      vecs[8]  = '{vi:1'b1, di:32'h5, ri:1'b0, ev:1'b0, er:1'b1, cd:1'b1, ed:32'hC};
      vecs[9]  = '{vi:1'b1, di:32'h6, ri:1'b1, ev:1'b1, er:1'b1, cd:1'b1, ed:32'h5};
      vecs[10] = '{vi:1'b0, di:32'h0, ri:1'b1, ev:1'b1, er:1'b1, cd:1'b1, ed:32'h6};
      vecs[11] = '{vi:1'b0, di:32'h0, ri:1'b0, ev:1'b0, er:1'b1, cd:1'b1, ed:32'h6};

      // Reset held with a beat offered upstream.
      rst_ni  = 1'b0;
      valid_i = 1'b1;
      data_i  = 32'h99;
      ready_i = 1'b0;
      repeat (3) @(negedge clk_i);
      checkOutput("rst_valid_o", {31'd0, valid_o}, 32'd0);
      checkOutput("rst_ready_o", {31'd0, ready_o}, 32'd0);
      checkOutput("rst_data_o", data_o, ResetValue);
      rst_ni = 1'b1;
      #1;
      checkOutput("rel_ready_o_low", {31'd0, ready_o}, 32'd0);
      @(negedge clk_i);
      checkOutput("rel_ready_o_high", {31'd0, ready_o}, 32'd1);
      checkOutput("rel_valid_o", {31'd0, valid_o}, 32'd0);
      driveCycle(1'b1, 32'h99, 1'b1);
      checkOutput("first_valid_o", {31'd0, valid_o}, 32'd1);
      checkOutput("first_data_o", data_o, 32'h99);
      driveCycle(1'b0, 32'h0, 1'b1);
      driveCycle(1'b0, 32'h0, 1'b0);

      // Back-to-back streaming with one cycle of latency and no bubbles.
      for (int i = 1; i <= 16; i++) begin
         checkOutput("stream_ready_o", {31'd0, ready_o}, 32'd1);
         if (i >= 2) begin
            checkOutput("stream_valid_o", {31'd0, valid_o}, 32'd1);
            checkOutput("stream_data_o", data_o, 32'(i - 1));
         end
         driveCycle(1'b1, 32'(i), 1'b1);
      end
      checkOutput("stream_last_data_o", data_o, 32'h10);
      driveCycle(1'b0, 32'h0, 1'b1);
      driveCycle(1'b0, 32'h0, 1'b0);

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i]);
      end

      // Random valid/ready with upstream holding stalled beats.
      hold  = 1'b0;
      cur_v = 1'b0;
      cur_d = '0;
      sent  = 0;
      cyc   = 0;
      while ((sent < 10000 || hold) && cyc < 60000) begin
         if (!hold) begin
            cur_v = 1'($urandom_range(1, 0));
            cur_d = $urandom;
         end
         hold = cur_v && !ready_o;
         if (cur_v && ready_o) begin
            sent++;
         end
         driveCycle(cur_v, cur_d, 1'($urandom_range(1, 0)));
         cyc++;
      end
      checkOutput("rand_beats_sent", 32'(sent), 32'd10000);
      guard = 0;
      while ((sb_q.size() != 0 || valid_o) && guard < 10) begin
         driveCycle(1'b0, 32'h0, 1'b1);
         guard++;
      end
      checkOutput("rand_drained", 32'(sb_q.size()), 32'd0);
      driveCycle(1'b0, 32'h0, 1'b0);

      // Reset while full discards both held beats.
      driveCycle(1'b1, 32'h7, 1'b0);
      driveCycle(1'b1, 32'h8, 1'b0);
      checkOutput("pre_rst_full_ready_o", {31'd0, ready_o}, 32'd0);
      checkOutput("pre_rst_full_data_o", data_o, 32'h7);
      valid_i = 1'b0;
      rst_ni  = 1'b0;
      #1;
      checkOutput("async_rst_valid_o", {31'd0, valid_o}, 32'd0);
      checkOutput("async_rst_data_o", data_o, ResetValue);
      sb_q.delete();
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int i = 0; i < 5; i++) begin
         driveCycle(1'b0, 32'h0, 1'b1);
         checkOutput("post_rst_valid_o", {31'd0, valid_o}, 32'd0);
         checkOutput("post_rst_data_o", data_o, ResetValue);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
